// File: rtl/ka_mul_pipe.sv
// Pipelined one-level Karatsuba multiplier: unsigned WIDTH x WIDTH -> 2*WIDTH, three registered
// stages with valid/ready flow control, per-stage bubble collapse, a pass-through tag and occupancy.
module ka_mul_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [TAG_W-1:0]   out_tag,
  output logic [1:0]         occupancy
);
  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned PW = 2 * WIDTH;

  logic             r_v1, r_v2, r_v3;
  logic [H-1:0]     r_ah, r_al, r_bh, r_bl;
  logic [H:0]       r_sa, r_sb;
  logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;
  logic [2*H-1:0]   r_z2, r_z0;
  logic [2*H+1:0]   r_zm;
  logic [PW-1:0]    r_prod;
  logic [1:0]       r_occ;

  logic             w_adv1, w_adv2, w_adv3;
  logic             w_v1_nx, w_v2_nx, w_v3_nx;
  logic [H-1:0]     w_ah, w_al, w_bh, w_bl;
  logic [H:0]       w_sa, w_sb;
  logic [2*H-1:0]   w_z2, w_z0;
  logic [2*H+1:0]   w_zm, w_mid;
  logic [PW-1:0]    w_prod;

  // An empty stage always advances, so a stalled output still lets upstream stages fill.
  always_comb begin
    w_adv3  = ~r_v3 | out_ready;
    w_adv2  = ~r_v2 | w_adv3;
    w_adv1  = ~r_v1 | w_adv2;
    w_v1_nx = w_adv1 ? in_valid : r_v1;
    w_v2_nx = w_adv2 ? r_v1     : r_v2;
    w_v3_nx = w_adv3 ? r_v2     : r_v3;
  end

  always_comb begin
    w_ah = a[WIDTH-1:H];
    w_al = a[H-1:0];
    w_bh = b[WIDTH-1:H];
    w_bl = b[H-1:0];
    w_sa = {1'b0, w_ah} + {1'b0, w_al};
    w_sb = {1'b0, w_bh} + {1'b0, w_bl};
    w_z2 = {{H{1'b0}}, r_ah} * {{H{1'b0}}, r_bh};
    w_z0 = {{H{1'b0}}, r_al} * {{H{1'b0}}, r_bl};
    w_zm = {{(H+1){1'b0}}, r_sa} * {{(H+1){1'b0}}, r_sb};
    // zm - z2 - z0 = aH*bL + aL*bH, never negative, fits in 2H+2 bits.
    w_mid  = r_zm - {2'b00, r_z2} - {2'b00, r_z0};
    w_prod = {r_z2, {WIDTH{1'b0}}} + (PW'(w_mid) << H) + {{WIDTH{1'b0}}, r_z0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_ah   <= '0;
      r_al   <= '0;
      r_bh   <= '0;
      r_bl   <= '0;
      r_sa   <= '0;
      r_sb   <= '0;
      r_tag1 <= '0;
      r_z2   <= '0;
      r_z0   <= '0;
      r_zm   <= '0;
      r_tag2 <= '0;
      r_prod <= '0;
      r_tag3 <= '0;
      r_occ  <= '0;
    end else begin
      r_v1  <= w_v1_nx;
      r_v2  <= w_v2_nx;
      r_v3  <= w_v3_nx;
      r_occ <= 2'(w_v1_nx) + 2'(w_v2_nx) + 2'(w_v3_nx);
      if (w_adv1) begin
        r_ah   <= w_ah;
        r_al   <= w_al;
        r_bh   <= w_bh;
        r_bl   <= w_bl;
        r_sa   <= w_sa;
        r_sb   <= w_sb;
        r_tag1 <= in_tag;
      end
      if (w_adv2) begin
        r_z2   <= w_z2;
        r_z0   <= w_z0;
        r_zm   <= w_zm;
        r_tag2 <= r_tag1;
      end
      if (w_adv3) begin
        r_prod <= w_prod;
        r_tag3 <= r_tag2;
      end
    end
  end

  assign in_ready  = w_adv1;
  assign out_valid = r_v3;
  assign product   = r_prod;
  assign out_tag   = r_tag3;
  assign occupancy = r_occ;
endmodule

// File: tb/tb_ka_mul_pipe.sv
// Directed and scoreboarded checks of ka_mul_pipe at WIDTH 32, plus scoreboarded runs at 16 and 64.
module tb_ka_mul_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b;
  logic [7:0]  in_tag, out_tag;
  logic [63:0] product;
  logic [1:0]  occupancy;

  logic        iv16, ir16, ov16, or16;
  logic [15:0] a16, b16;
  logic [7:0]  it16, ot16;
  logic [31:0] p16;
  logic [1:0]  oc16;

  logic         iv64, ir64, ov64, or64;
  logic [63:0]  a64, b64;
  logic [7:0]   it64, ot64;
  logic [127:0] p64;
  logic [1:0]   oc64;

  ka_mul_pipe #(.WIDTH(32), .TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .out_tag(out_tag), .occupancy(occupancy));

  ka_mul_pipe #(.WIDTH(16), .TAG_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .in_tag(it16), .out_valid(ov16), .out_ready(or16), .product(p16),
    .out_tag(ot16), .occupancy(oc16));

  ka_mul_pipe #(.WIDTH(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
    .in_tag(it64), .out_valid(ov64), .out_ready(or64), .product(p64),
    .out_tag(ot64), .occupancy(oc64));

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  logic [127:0] q_prod[$];
  logic [7:0]   q_tag[$];

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_total++; if (product !== 64'd0) $display("FAIL reset_product got %h exp 0", product); else n_pass++;
    n_total++; if (out_tag !== 8'd0) $display("FAIL reset_out_tag got %h exp 0", out_tag); else n_pass++;
    n_total++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy got %0d exp 0", occupancy); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    a = 32'd3; b = 32'd5; in_tag = 8'h11; in_valid = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL single_in_ready got %b exp 1", in_ready); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b0 || occupancy !== 2'd1)
      $display("FAIL single_edge1 got v=%b occ=%0d exp v=0 occ=1", out_valid, occupancy); else n_pass++;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0 || occupancy !== 2'd1)
      $display("FAIL single_edge2 got v=%b occ=%0d exp v=0 occ=1", out_valid, occupancy); else n_pass++;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b1 || occupancy !== 2'd1)
      $display("FAIL single_edge3 got v=%b occ=%0d exp v=1 occ=1", out_valid, occupancy); else n_pass++;
    n_total++; if (product !== 64'd15) $display("FAIL single_product got %0d exp 15", product); else n_pass++;
    n_total++; if (out_tag !== 8'h11) $display("FAIL single_tag got %h exp 11", out_tag); else n_pass++;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL single_drain got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); else n_pass++;
  endtask

  task automatic test_carry();
    int unsigned lat;
    out_ready = 1'b1;
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_tag = 8'hC3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_total++; if (lat != 3) $display("FAIL carry_latency got %0d exp 3", lat); else n_pass++;
    n_total++; if (product !== 64'hFFFF_FFFE_0000_0001)
      $display("FAIL carry_product got %h exp fffffffe00000001", product); else n_pass++;
    n_total++; if (out_tag !== 8'hC3) $display("FAIL carry_tag got %h exp c3", out_tag); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int unsigned i = 0, got = 0, iters = 0;
    logic [63:0] ep;
    logic [7:0]  et;
    q_prod.delete(); q_tag.delete();
    out_ready = 1'b1;
    while (got < 501 && iters < 700) begin
      if (out_valid === 1'b1) begin
        if (q_prod.size() == 0) begin
          n_total++; $display("FAIL b2b_spurious got %h exp none", product);
        end else begin
          ep = 64'(q_prod.pop_front()); et = q_tag.pop_front();
          n_total++; if (product !== ep || out_tag !== et)
            $display("FAIL b2b_item%0d got %h/%h exp %h/%h", got, product, out_tag, ep, et); else n_pass++;
        end
        got++;
      end
      in_valid = (i <= 500);
      a = i; b = i + 1; in_tag = i[7:0];
      #1;
      if (in_valid && in_ready) begin
        q_prod.push_back(128'(64'(i) * 64'(i + 1)));
        q_tag.push_back(i[7:0]);
        i++;
      end
      @(negedge clk);
      iters++;
    end
    in_valid = 1'b0;
    n_total++; if (got != 501 || iters != 504)
      $display("FAIL b2b_throughput got %0d items in %0d cycles exp 501 in 504", got, iters); else n_pass++;
  endtask

  task automatic test_stall();
    int unsigned k = 0, got = 0, c = 0;
    logic [63:0] ep;
    logic [7:0]  et;
    q_prod.delete(); q_tag.delete();
    out_ready = 1'b0;
    for (int s = 0; s < 6; s++) begin
      in_valid = (k < 5); a = 100 + k; b = 200 + k; in_tag = 8'h40 + 8'(k);
      #1;
      if (in_valid && in_ready) begin
        q_prod.push_back(128'(64'(100 + k) * 64'(200 + k)));
        q_tag.push_back(8'h40 + 8'(k));
        k++;
      end
      @(negedge clk);
    end
    #1;
    n_total++; if (k != 3) $display("FAIL stall_accepted got %0d exp 3", k); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %b exp 0", in_ready); else n_pass++;
    n_total++; if (occupancy !== 2'd3) $display("FAIL stall_occupancy got %0d exp 3", occupancy); else n_pass++;
    n_total++; if (out_valid !== 1'b1 || product !== 64'd20000 || out_tag !== 8'h40)
      $display("FAIL stall_hold got v=%b %0d/%h exp v=1 20000/40", out_valid, product, out_tag); else n_pass++;
    out_ready = 1'b1;
    while ((got < 5 || k < 5) && c < 20) begin
      if (c == 1) begin
        n_total++; if (occupancy !== 2'd3) $display("FAIL stall_full_shift_occ got %0d exp 3", occupancy); else n_pass++;
      end
      if (out_valid === 1'b1) begin
        if (q_prod.size() == 0) begin
          n_total++; $display("FAIL stall_spurious got %h exp none", product);
        end else begin
          ep = 64'(q_prod.pop_front()); et = q_tag.pop_front();
          n_total++; if (product !== ep || out_tag !== et)
            $display("FAIL stall_item%0d got %0d/%h exp %0d/%h", got, product, out_tag, ep, et); else n_pass++;
        end
        got++;
      end
      in_valid = (k < 5); a = 100 + k; b = 200 + k; in_tag = 8'h40 + 8'(k);
      #1;
      if (c == 0) begin
        n_total++; if (in_ready !== 1'b1) $display("FAIL stall_full_accept got %b exp 1", in_ready); else n_pass++;
      end
      if (in_valid && in_ready) begin
        q_prod.push_back(128'(64'(100 + k) * 64'(200 + k)));
        q_tag.push_back(8'h40 + 8'(k));
        k++;
      end
      @(negedge clk);
      c++;
    end
    in_valid = 1'b0;
    n_total++; if (got != 5 || q_prod.size() != 0)
      $display("FAIL stall_count got %0d left %0d exp 5 left 0", got, q_prod.size()); else n_pass++;
  endtask

  task automatic test_random();
    int unsigned sent = 0, got = 0, cyc = 0;
    logic        held = 1'b0;
    logic [63:0] hp, ep;
    logic [7:0]  ht, et;
    q_prod.delete(); q_tag.delete();
    while (got < 10000 && cyc < 40000) begin
      if (held) begin
        n_total++; if (out_valid !== 1'b1 || product !== hp || out_tag !== ht)
          $display("FAIL rand_hold got v=%b %h/%h exp v=1 %h/%h", out_valid, product, out_tag, hp, ht); else n_pass++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid === 1'b1 && out_ready) begin
        if (q_prod.size() == 0) begin
          n_total++; $display("FAIL rand_spurious got %h exp none", product);
        end else begin
          ep = 64'(q_prod.pop_front()); et = q_tag.pop_front();
          n_total++; if (product !== ep || out_tag !== et)
            $display("FAIL rand_item%0d got %h/%h exp %h/%h", got, product, out_tag, ep, et); else n_pass++;
        end
        got++;
      end
      held = (out_valid === 1'b1) && !out_ready;
      hp = product; ht = out_tag;
      in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
      a = $urandom; b = $urandom; in_tag = 8'($urandom);
      #1;
      if (in_valid && in_ready) begin
        q_prod.push_back(128'({32'd0, a} * {32'd0, b}));
        q_tag.push_back(in_tag);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_total++; if (got != 10000) $display("FAIL rand_count got %0d exp 10000", got); else n_pass++;
  endtask

  task automatic test_width16();
    int unsigned sent = 0, got = 0, cyc = 0;
    logic [31:0] ep;
    logic [7:0]  et;
    q_prod.delete(); q_tag.delete();
    n_total++; if (p16 !== 32'd0 || ov16 !== 1'b0) $display("FAIL w16_idle got v=%b %h exp v=0 0", ov16, p16); else n_pass++;
    while (got < 3000 && cyc < 15000) begin
      or16 = ($urandom_range(0, 3) != 0);
      if (ov16 === 1'b1 && or16) begin
        if (q_prod.size() == 0) begin
          n_total++; $display("FAIL w16_spurious got %h exp none", p16);
        end else begin
          ep = 32'(q_prod.pop_front()); et = q_tag.pop_front();
          n_total++; if (p16 !== ep || ot16 !== et)
            $display("FAIL w16_item%0d got %h/%h exp %h/%h", got, p16, ot16, ep, et); else n_pass++;
        end
        got++;
      end
      iv16 = (sent < 3000) && ($urandom_range(0, 3) != 0);
      a16 = (sent == 0) ? 16'hFFFF : 16'($urandom);
      b16 = (sent == 0) ? 16'hFFFF : 16'($urandom);
      it16 = 8'($urandom);
      #1;
      if (iv16 && ir16) begin
        q_prod.push_back(128'({16'd0, a16} * {16'd0, b16}));
        q_tag.push_back(it16);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    iv16 = 1'b0;
    n_total++; if (got != 3000) $display("FAIL w16_count got %0d exp 3000", got); else n_pass++;
  endtask

  task automatic test_width64();
    int unsigned sent = 0, got = 0, cyc = 0;
    logic [127:0] ep;
    logic [7:0]   et;
    q_prod.delete(); q_tag.delete();
    while (got < 3000 && cyc < 15000) begin
      or64 = ($urandom_range(0, 3) != 0);
      if (ov64 === 1'b1 && or64) begin
        if (q_prod.size() == 0) begin
          n_total++; $display("FAIL w64_spurious got %h exp none", p64);
        end else begin
          ep = q_prod.pop_front(); et = q_tag.pop_front();
          n_total++; if (p64 !== ep || ot64 !== et)
            $display("FAIL w64_item%0d got %h/%h exp %h/%h", got, p64, ot64, ep, et); else n_pass++;
        end
        got++;
      end
      iv64 = (sent < 3000) && ($urandom_range(0, 3) != 0);
      a64 = (sent == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      b64 = (sent == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      it64 = 8'($urandom);
      #1;
      if (iv64 && ir64) begin
        q_prod.push_back({64'd0, a64} * {64'd0, b64});
        q_tag.push_back(it64);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    iv64 = 1'b0;
    n_total++; if (got != 3000) $display("FAIL w64_count got %0d exp 3000", got); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    int unsigned seen = 0, lat;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; a = 32'd11 + 32'(c); b = 32'd13; in_tag = 8'(c);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_total++; if (occupancy !== 2'd3) $display("FAIL mid_prefill_occ got %0d exp 3", occupancy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL mid_reset got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      if (out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    n_total++; if (seen != 0) $display("FAIL mid_no_output got %0d outputs exp 0", seen); else n_pass++;
    a = 32'd7; b = 32'd9; in_tag = 8'h77; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_total++; if (lat != 3 || product !== 64'd63 || out_tag !== 8'h77)
      $display("FAIL mid_after lat=%0d %0d/%h exp lat=3 63/77", lat, product, out_tag); else n_pass++;
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; in_tag = '0;
    iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; it16 = '0;
    iv64 = 1'b0; or64 = 1'b0; a64 = '0; b64 = '0; it64 = '0;
    test_reset();
    test_single();
    test_carry();
    test_back_to_back();
    test_stall();
    test_random();
    test_width16();
    test_width64();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
